// File: rtl/myfunc_sweep_ctrl.sv
// myfunc_sweep_ctrl: sweeps the 16 input combinations of a myfunc cell, captures its truth table and checks it against EXPECTED
module myfunc_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] EXPECTED = 16'hFF50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        dut_a,
  output logic        dut_b,
  output logic        dut_c,
  output logic        dut_d,
  input  logic        dut_o,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err_idx,
  output logic        err_valid,
  output logic        pass
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  state_t state;
  logic [3:0] idx, cnt;
  logic bit_o, miss;
  assign bit_o = (dut_o === 1'b1);
  assign miss = bit_o != EXPECTED[idx];
  assign {dut_a, dut_b, dut_c, dut_d} = busy ? idx : 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      table_out <= '0;
      err_count <= '0;
      first_err_idx <= '0;
      err_valid <= 1'b0;
      pass <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state <= DRIVE;
          idx <= '0;
          cnt <= '0;
          busy <= 1'b1;
          table_out <= '0;
          err_count <= '0;
          first_err_idx <= '0;
          err_valid <= 1'b0;
          pass <= 1'b0;
        end
        DRIVE: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          cnt <= cnt + 4'd1;
          state <= (cnt == SETTLE_LAST) ? SAMPLE : DRIVE;
        end
        SAMPLE: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          table_out[idx] <= bit_o;
          if (miss) begin
            err_count <= err_count + 5'd1;
            if (!err_valid) begin
              first_err_idx <= idx;
              err_valid <= 1'b1;
            end
          end
          if (idx == 4'd15) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= DRIVE;
            idx <= idx + 4'd1;
            cnt <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          pass <= (err_count == 5'd0);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_myfunc_sweep_ctrl.sv
// tb_myfunc_sweep_ctrl: checks the sweep controller against a truth-table reference model
module tb_myfunc_sweep_ctrl;
  localparam logic [15:0] GOLD = 16'hFF50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic busy0, done0, a0, b0, c0, d0, o0, ev0, pass0;
  logic busy1, done1, a1, b1, c1, d1, o1, ev1, pass1;
  logic [15:0] tbl0 = GOLD, tbl1 = GOLD, tout0, tout1;
  logic [4:0] ec0, ec1;
  logic [3:0] fi0, fi1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  assign o0 = tbl0[{a0, b0, c0, d0}];
  assign o1 = tbl1[{a1, b1, c1, d1}];
  myfunc_sweep_ctrl #(.SETTLE(2), .EXPECTED(GOLD)) u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0), .dut_o(o0), .table_out(tout0),
    .err_count(ec0), .first_err_idx(fi0), .err_valid(ev0), .pass(pass0));
  myfunc_sweep_ctrl #(.SETTLE(1), .EXPECTED(GOLD)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1), .dut_o(o1), .table_out(tout1),
    .err_count(ec1), .first_err_idx(fi1), .err_valid(ev1), .pass(pass1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_idle0(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_pins"}, {a0, b0, c0, d0}, 0);
  endtask
  task automatic chk_results0(input string tag, input logic [15:0] t, input int k, input bit full);
    logic [15:0] mask, rec, diff;
    int fi;
    mask = (k >= 16) ? 16'hFFFF : 16'((1 << k) - 1);
    rec = t & mask;
    diff = (rec ^ GOLD) & mask;
    fi = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) fi = i;
    chk({tag, "_table"}, tout0, rec);
    chk({tag, "_errcnt"}, ec0, $countones(diff));
    chk({tag, "_firstidx"}, fi0, fi);
    chk({tag, "_errvalid"}, ev0, diff != 0);
    chk({tag, "_pass"}, pass0, full && diff == 0);
  endtask
  task automatic run0(input string tag, input logic [15:0] t, input int abort_cyc);
    int k;
    bit aborted;
    tbl0 = t;
    aborted = 0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int n = 0; n < 48; n++) begin
      if (abort_cyc >= 0 && n == abort_cyc + 1) begin
        chk_idle0({tag, "_abort"});
        aborted = 1;
        break;
      end
      chk({tag, "_busy"}, busy0, 1);
      chk({tag, "_nodone"}, done0, 0);
      chk({tag, "_pins"}, {a0, b0, c0, d0}, n / 3);
      if (n == 10) start0 = 1'b1;
      if (n == abort_cyc) abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      abort0 = 1'b0;
    end
    if (aborted) begin
      k = abort_cyc / 3;
      repeat (3) begin
        @(negedge clk);
        chk_idle0({tag, "_after_abort"});
      end
      chk_results0(tag, t, k, 0);
    end else begin
      chk({tag, "_done48"}, done0, 1);
      chk({tag, "_busy48"}, busy0, 0);
      chk({tag, "_pins48"}, {a0, b0, c0, d0}, 0);
      @(negedge clk);
      chk({tag, "_donepulse"}, done0, 0);
      chk_results0(tag, t, 16, 1);
    end
  endtask
  initial begin
    int n;
    int seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle0("reset");
    chk("reset_table", tout0, 0);
    chk("reset_pass", pass0, 0);
    run0("golden", GOLD, -1);
    run0("stuck0", 16'h0000, -1);
    run0("inv9", GOLD ^ 16'h0200, -1);
    run0("abort7", GOLD, 21);
    chk("abort7_tablehi", tout0[15:7], 0);
    run0("golden_again", GOLD, -1);
    repeat (4) run0("rand", 16'($urandom), -1);
    repeat (3) run0("rand_abort", 16'($urandom), $urandom_range(12, 46));
    @(negedge clk) begin start0 = 1'b1; abort0 = 1'b1; end
    @(negedge clk) begin start0 = 1'b0; abort0 = 1'b0; end
    chk_idle0("start_abort_idle");
    tbl0 = 16'($urandom);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle0("midreset");
    chk("midreset_table", tout0, 0);
    chk("midreset_errcnt", ec0, 0);
    chk("midreset_firstidx", fi0, 0);
    chk("midreset_errvalid", ev0, 0);
    chk("midreset_pass", pass0, 0);
    tbl1 = GOLD;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk);
    seen = 0;
    for (n = 0; n < 40; n++) begin
      if (done1) begin
        seen++;
        chk("s1_done_cycle", n, 32);
      end
      chk("s1_busy", busy1, n < 32 || n >= 34);
      chk("s1_pins", {a1, b1, c1, d1}, n < 32 ? n / 2 : (n < 34 ? 0 : (n - 34) / 2));
      @(negedge clk);
    end
    start1 = 1'b0;
    chk("s1_done_count", seen, 1);
    while (!done1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("s1_second_done_cycle", n, 66);
    @(negedge clk);
    chk("s1_table", tout1, GOLD);
    chk("s1_errcnt", ec1, 0);
    chk("s1_pass", pass1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
